reg_block: RTL and testbench

REG_BLOCK -- requirements
Module: reg_block

---
 rtl/reg_block_pkg.sv | 7 +
 rtl/reg_block_if.sv | 19 +
 rtl/reg_block.sv | 80 ++++++++
 tb/tb_reg_block.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/reg_block_pkg.sv
// Shared types and default sizing for the register block.
package reg_block_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
endpackage

// File: rtl/reg_block_if.sv
// Register block access bus: two read ports, one write port, clear request.
interface reg_block_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) ();
  logic             en;
  logic [AW-1:0]    ra;
  logic [AW-1:0]    rb;
  logic             we;
  logic [AW-1:0]    w;
  logic [WIDTH-1:0] wd;
  logic             clr_req;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] f;
  logic             busy;

  modport master (output en, ra, rb, we, w, wd, clr_req, input e, f, busy);
  modport slave  (input en, ra, rb, we, w, wd, clr_req, output e, f, busy);
endinterface

// File: rtl/reg_block.sv
// Register file with two registered read ports, write-first bypass and a
// one-entry-per-cycle clear sweep.
module reg_block
  import reg_block_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1
) (
  input  logic       clk,
  input  logic       rs_n,
  reg_block_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_e, r_f;
  logic [AW-1:0]    r_cnt;
  logic             r_busy;
  state_t           r_state;

  logic             w_wr_en;
  logic [WIDTH-1:0] w_rd_a, w_rd_b;

  assign w_wr_en = (r_state == IDLE) && bus.we && ({1'b0, bus.w} < DEPTH_A) &&
                   !((ZERO_REG != 0) && (bus.w == '0));

  // Out-of-range addresses never match an entry, so they read as zero; the
  // bypass can only hit in-range addresses because w_wr_en already checks w.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.ra == AW'(i)) w_rd_a = r_mem[i];
      if (bus.rb == AW'(i)) w_rd_b = r_mem[i];
    end
    if (w_wr_en && (bus.w == bus.ra)) w_rd_a = bus.wd;
    if (w_wr_en && (bus.w == bus.rb)) w_rd_b = bus.wd;
    if ((ZERO_REG != 0) && (bus.ra == '0)) w_rd_a = '0;
    if ((ZERO_REG != 0) && (bus.rb == '0)) w_rd_b = '0;
  end

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_e     <= '0;
      r_f     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_state <= IDLE;
    end else if (r_state == IDLE) begin
      for (int i = 0; i < DEPTH; i++)
        if (w_wr_en && (bus.w == AW'(i))) r_mem[i] <= bus.wd;
      if (bus.en) begin
        r_e <= w_rd_a;
        r_f <= w_rd_b;
      end
      // A write on the request edge lands first; the sweep then clears it.
      if (bus.clr_req) begin
        r_state <= CLEAR;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (r_cnt == AW'(i)) r_mem[i] <= '0;
      if (r_cnt == AW'(DEPTH-1)) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        r_cnt <= r_cnt + AW'(1);
      end
    end
  end

  assign bus.e    = r_e;
  assign bus.f    = r_f;
  assign bus.busy = r_busy;
endmodule

// File: tb/tb_reg_block.sv
// Directed bench for reg_block: default 32-deep instance plus a 24-deep one.
module tb_reg_block;
  logic clk = 1'b0;
  logic rs_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_block_if #(.WIDTH(32), .AW(5)) b1 ();
  reg_block_if #(.WIDTH(32), .AW(5)) b2 ();

  reg_block #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u_d32 (.clk(clk), .rs_n(rs_n), .bus(b1));
  reg_block #(.WIDTH(32), .DEPTH(24), .ZERO_REG(0)) u_d24 (.clk(clk), .rs_n(rs_n), .bus(b2));

  typedef struct {
    logic        we;
    logic [4:0]  w;
    logic [31:0] wd;
    logic        en;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ee;
    logic [31:0] ef;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;

    tv[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0};
    tv[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    tv[2] = '{1'b1, 5'd0,  32'h1234,     1'b1, 5'd0,  5'd0,  32'h0,        32'h0};
    tv[3] = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd5,  5'd3,  32'hDEADBEEF, 32'h11};
    tv[4] = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b1, 5'd7,  5'd3,  32'hA5A5A5A5, 32'h11};
    tv[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  32'hA5A5A5A5, 32'h11};
    tv[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd7,  32'h0,        32'hA5A5A5A5};
    tv[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 5'd5,  32'hFFFFFFFF, 32'hDEADBEEF};
    tv[8] = '{1'b1, 5'd5,  32'h0,        1'b1, 5'd3,  5'd5,  32'h11,       32'h0};
    tv[9] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd31, 32'h0,        32'hFFFFFFFF};

    {b1.en, b1.ra, b1.rb, b1.we, b1.w, b1.wd, b1.clr_req} = '0;
    {b2.en, b2.ra, b2.rb, b2.we, b2.w, b2.wd, b2.clr_req} = '0;
    step();
    step();
    chk("rst_e",    b1.e, 0);
    chk("rst_f",    b1.f, 0);
    chk("rst_busy", b1.busy, 0);
    chk("rst_busy24", b2.busy, 0);
    rs_n = 1'b1;

    // table-driven read/write/bypass vectors
    for (int i = 0; i < 10; i++) begin
      b1.we = tv[i].we; b1.w = tv[i].w; b1.wd = tv[i].wd;
      b1.en = tv[i].en; b1.ra = tv[i].ra; b1.rb = tv[i].rb;
      step();
      chk($sformatf("vec%0d_e", i), b1.e, tv[i].ee);
      chk($sformatf("vec%0d_f", i), b1.f, tv[i].ef);
    end
    b1.we = 1'b0;
    b1.ra = 5'd0; b1.rb = 5'd0;
    step();
    chk("zero_reg_later", b1.e, 0);

    // fill everything, then clear with a same-edge write
    b1.en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      b1.we = 1'b1; b1.w = 5'(i); b1.wd = 32'(i + 100);
      step();
    end
    b1.en = 1'b1; b1.ra = 5'd12; b1.rb = 5'd31; b1.we = 1'b0;
    step();
    chk("fill_e", b1.e, 112);
    chk("fill_f", b1.f, 131);
    b1.we = 1'b1; b1.w = 5'd9; b1.wd = 32'h99; b1.ra = 5'd9; b1.clr_req = 1'b1;
    step();
    chk("clr_start_busy", b1.busy, 1);
    chk("clr_same_edge_wr", b1.e, 32'h99);
    cnt = 1;
    b1.clr_req = 1'b0;
    b1.w = 5'd2; b1.wd = 32'h777; b1.ra = 5'd2;
    for (int k = 0; k < 100; k++) begin
      step();
      if (b1.busy) cnt++;
      else break;
    end
    b1.we = 1'b0;
    chk("clr_busy_cycles", cnt, 32);
    chk("clr_e_held", b1.e, 32'h99);
    for (int i = 0; i < 32; i++) begin
      b1.ra = 5'(i); b1.rb = 5'(31 - i);
      step();
      chk($sformatf("cleared_a%0d", i), b1.e, 0);
      chk($sformatf("cleared_b%0d", 31 - i), b1.f, 0);
    end

    // reset in the middle of a sweep
    b1.we = 1'b1; b1.w = 5'd20; b1.wd = 32'h2020;
    step();
    b1.w = 5'd4; b1.wd = 32'h44; b1.ra = 5'd4; b1.rb = 5'd20;
    step();
    chk("pre_rst_e", b1.e, 32'h44);
    chk("pre_rst_f", b1.f, 32'h2020);
    b1.we = 1'b0; b1.clr_req = 1'b1;
    step();
    b1.clr_req = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("mid_sweep_busy", b1.busy, 1);
    rs_n = 1'b0;
    #1;
    chk("abort_busy", b1.busy, 0);
    chk("abort_e", b1.e, 0);
    chk("abort_f", b1.f, 0);
    rs_n = 1'b1;
    b1.we = 1'b1; b1.w = 5'd6; b1.wd = 32'h55AA; b1.ra = 5'd20; b1.rb = 5'd4;
    step();
    chk("post_rst_r20", b1.e, 0);
    chk("post_rst_r4", b1.f, 0);
    b1.we = 1'b0; b1.ra = 5'd6; b1.rb = 5'd20;
    step();
    chk("post_rst_wr", b1.e, 32'h55AA);
    chk("post_rst_busy", b1.busy, 0);

    // 24-deep instance, register 0 writable
    b2.en = 1'b1; b2.we = 1'b1; b2.w = 5'd30; b2.wd = 32'hBAD; b2.ra = 5'd30; b2.rb = 5'd23;
    step();
    chk("d24_oor_bypass", b2.e, 0);
    chk("d24_r23_init", b2.f, 0);
    b2.w = 5'd23; b2.wd = 32'h2323; b2.ra = 5'd23; b2.rb = 5'd30;
    step();
    chk("d24_r23_bypass", b2.e, 32'h2323);
    chk("d24_oor_read", b2.f, 0);
    b2.w = 5'd0; b2.wd = 32'h77; b2.ra = 5'd0; b2.rb = 5'd23;
    step();
    chk("d24_r0_bypass", b2.e, 32'h77);
    chk("d24_r23", b2.f, 32'h2323);
    b2.we = 1'b0; b2.ra = 5'd0; b2.rb = 5'd30;
    step();
    chk("d24_r0_stored", b2.e, 32'h77);
    chk("d24_oor_after", b2.f, 0);
    b2.clr_req = 1'b1;
    step();
    b2.clr_req = 1'b0;
    cnt = b2.busy ? 1 : 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (b2.busy) cnt++;
      else break;
    end
    chk("d24_busy_cycles", cnt, 24);
    b2.ra = 5'd23; b2.rb = 5'd0;
    step();
    chk("d24_cleared_23", b2.e, 0);
    chk("d24_cleared_0", b2.f, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
